alarm_buzzer: RTL

//  Downstream of the alarm-clock top: consumes the alarm-on level and drives a piezo with a beeping square-wave tone.

---
 rtl/alarm_clock_pkg.sv | 18 +
 rtl/tick_divider.sv | 29 ++
 rtl/alarm_buzzer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: buzzer FSM state encodings and timebase constants.
package alarm_clock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int MS_PER_S = 1000;

   // Counter width for a counter that runs 0 .. n-1; never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider: one-cycle o_Tick every CLK_IN/TICK_HZ cycles.
// i_Restart zeroes the count so the first tick lands a full period after restart.
module tick_divider #(
   parameter int CLK_IN  = 5000000,
   parameter int TICK_HZ = 1000
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Restart,
   output logic o_Tick
);

   localparam int DIV = CLK_IN / TICK_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge i_Clk) begin
      if (i_Reset || i_Restart)
         cnt <= '0;
      else if (cnt == CW'(DIV - 1))
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign o_Tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/alarm_buzzer.sv
// Alarm buzzer: beeping piezo tone with snooze, dismiss and ring timeout.
// All outputs registered; alarm level seen in cycle n rings in cycle n+1.
module alarm_buzzer
   import alarm_clock_pkg::*;
#(
   parameter int CLK_IN      = 5000000,
   parameter int TONE_HZ     = 2000,
   parameter int BEEP_ON_MS  = 250,
   parameter int BEEP_OFF_MS = 250,
   parameter int SNOOZE_S    = 300,
   parameter int TIMEOUT_S   = 60
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Alarm_On,
   input  logic i_Snooze,
   input  logic i_Dismiss,
   output logic o_Buzzer,
   output logic o_Ringing,
   output logic o_Snoozed
);

   localparam int CAD_N = BEEP_ON_MS + BEEP_OFF_MS;
   localparam int CAD_W = cnt_w(CAD_N);
   localparam int SEC_N = (TIMEOUT_S > SNOOZE_S) ? TIMEOUT_S : SNOOZE_S;
   localparam int SEC_W = cnt_w(SEC_N);
   localparam int MS_W  = cnt_w(MS_PER_S);

   state_t             state, state_nx;
   logic [MS_W-1:0]    ms_cnt, ms_nx;
   logic [SEC_W-1:0]   sec, sec_nx;
   logic [CAD_W-1:0]   cad, cad_nx;
   logic               phase, phase_nx;
   logic               ms_tick, tone_tick, s_tick, restart;

   // Both dividers re-align on every state change so each state starts a fresh period.
   tick_divider #(.CLK_IN(CLK_IN), .TICK_HZ(MS_PER_S)) u_ms_div (
      .i_Clk     (i_Clk),
      .i_Reset   (i_Reset),
      .i_Restart (restart),
      .o_Tick    (ms_tick)
   );

   tick_divider #(.CLK_IN(CLK_IN), .TICK_HZ(2 * TONE_HZ)) u_tone_div (
      .i_Clk     (i_Clk),
      .i_Reset   (i_Reset),
      .i_Restart (restart),
      .o_Tick    (tone_tick)
   );

   assign s_tick = ms_tick && (ms_cnt == MS_W'(MS_PER_S - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_Alarm_On) state_nx = RING;
         RING: begin
            if (i_Dismiss)
               state_nx = DONE;
            else if (i_Snooze)
               state_nx = SNOOZE;
            else if (s_tick && sec == SEC_W'(TIMEOUT_S - 1))
               state_nx = DONE;
         end
         SNOOZE: begin
            if (i_Dismiss)
               state_nx = DONE;
            else if (s_tick && sec == SEC_W'(SNOOZE_S - 1))
               state_nx = RING;
         end
         DONE:    if (!i_Alarm_On) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign restart = (state_nx != state);

   always_comb begin
      ms_nx    = ms_cnt;
      sec_nx   = sec;
      cad_nx   = cad;
      phase_nx = phase;
      if (restart) begin
         ms_nx    = '0;
         sec_nx   = '0;
         cad_nx   = '0;
         phase_nx = 1'b1;
      end else begin
         if (ms_tick) begin
            ms_nx  = s_tick ? '0 : ms_cnt + MS_W'(1);
            cad_nx = (cad == CAD_W'(CAD_N - 1)) ? '0 : cad + CAD_W'(1);
         end
         if (s_tick)
            sec_nx = (sec == SEC_W'(SEC_N - 1)) ? '0 : sec + SEC_W'(1);
         if (tone_tick)
            phase_nx = ~phase;
      end
   end

   // Outputs are computed from next-state values so they line up with the state register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state     <= IDLE;
         ms_cnt    <= '0;
         sec       <= '0;
         cad       <= '0;
         phase     <= 1'b1;
         o_Buzzer  <= 1'b0;
         o_Ringing <= 1'b0;
         o_Snoozed <= 1'b0;
      end else begin
         state     <= state_nx;
         ms_cnt    <= ms_nx;
         sec       <= sec_nx;
         cad       <= cad_nx;
         phase     <= phase_nx;
         o_Ringing <= (state_nx == RING);
         o_Snoozed <= (state_nx == SNOOZE);
         o_Buzzer  <= (state_nx == RING) && phase_nx && (cad_nx < CAD_W'(BEEP_ON_MS));
      end
   end

endmodule
